// File: rtl/plab4_net_router_input_ctrl.sv
// Ring-router input stage: FIFO buffer, route the head message west/terminal/east, dequeue on grant.
// Min latency 1 cycle; in_rdy drops when full. Optional per-direction counters under PLAB4_NET_ROUTER_INPUT_STATS_EN.
module plab4_net_router_input_ctrl #(
  parameter int unsigned p_msg_nbits   = 44,
  parameter int unsigned p_dest_lsb    = 42,
  parameter int unsigned p_dest_nbits  = 2,
  parameter int unsigned p_num_routers = 4,
  parameter int unsigned p_router_id   = 0,
  parameter int unsigned p_num_entries = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [p_msg_nbits-1:0] in_msg,
  output logic [2:0]             reqs,
  input  logic [2:0]             grants,
  output logic [p_msg_nbits-1:0] head_msg
`ifdef PLAB4_NET_ROUTER_INPUT_STATS_EN
  ,
  output logic [47:0]            stats
`endif
);

  localparam int unsigned PTR_W = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;
  localparam int unsigned CNT_W = $clog2(p_num_entries + 1);

  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [p_msg_nbits-1:0] entries_q [p_num_entries];

  logic                    enq;
  logic                    deq;
  logic [p_dest_nbits-1:0] dest;
  int unsigned             d_e;

  // in_rdy is gated by the reset pin so it drops immediately on an asynchronous reset
  assign in_rdy   = reset && (count_q != CNT_W'(p_num_entries));
  assign enq      = in_val && in_rdy;
  assign deq      = |(reqs & grants);
  assign head_msg = entries_q[rd_ptr_q];
  assign dest     = head_msg[p_dest_lsb +: p_dest_nbits];

  always_comb begin
    reqs = 3'b000;
    d_e  = (32'(dest) + p_num_routers - p_router_id) % p_num_routers;
    if (count_q != '0) begin
      if (32'(dest) == p_router_id)
        reqs = 3'b010;
      else if (d_e <= p_num_routers / 2)
        reqs = 3'b100;
      else
        reqs = 3'b001;
    end
  end

  // Depth is a power of two, so pointers wrap naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) entries_q[wr_ptr_q] <= in_msg;
  end

`ifdef PLAB4_NET_ROUTER_INPUT_STATS_EN
  logic [15:0] dir_cnt_q [3];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) dir_cnt_q[i] <= '0;
    end else if (deq) begin
      for (int i = 0; i < 3; i++)
        if (reqs[i] && dir_cnt_q[i] != 16'hFFFF) dir_cnt_q[i] <= dir_cnt_q[i] + 16'd1;
    end
  end

  assign stats = {dir_cnt_q[2], dir_cnt_q[1], dir_cnt_q[0]};
`endif

`ifndef SYNTHESIS
  // Grants must be one-hot and only arrive while a request is outstanding
  a_grant_legal: assert property (@(posedge clk) disable iff (!reset)
    (grants != 3'b000) |-> ((reqs != 3'b000) && $onehot(grants)))
    else $error("illegal grant %b with reqs %b", grants, reqs);
`endif

endmodule
